// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, recovered word and status out.
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data; there is no
// ready, so the consumer must capture rx_data in the cycle rx_valid is high.
// rx_frame_err is a one-cycle strobe and is never high together with rx_valid.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 uart_rx_data;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_frame_err;
  logic                 uart_busy;

  // Receiver side: samples the line, produces words and status.
  modport master (
    input  uart_rx_data,
    output rx_data,
    output rx_valid,
    output rx_frame_err,
    output uart_busy
  );

  // Consumer side: drives the line (bench or loopback), reads words.
  modport slave (
    output uart_rx_data,
    input  rx_data,
    input  rx_valid,
    input  rx_frame_err,
    input  uart_busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start bit 0, DATA_BITS data bits MSB-first, one stop bit 1.
// Each bit is decided by a 3-sample majority around mid-bit; the stop bit
// decision returns to IDLE straight away so back-to-back frames resync.
// DATA_BITS must be at least 2 and CLKS_PER_BIT at least 8.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic       RST_clk,
  input  logic       RST,
  uart_rx_if.master  rx_bus,
  output logic [1:0] o_dbg_state
);

  localparam int M     = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_SMP_A  = CNT_W'(M - 1);
  localparam logic [CNT_W-1:0] CNT_SMP_B  = CNT_W'(M);
  localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(M + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Synchronizer, edge history and fill tracking
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_hist;
  logic [1:0]           r_fill;

  // FSM and bit timing
  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_clk_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [IDX_W-1:0]     w_bit_nxt;

  // Sampling and data path
  logic                 r_smp_a;
  logic                 r_smp_b;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_valid;
  logic                 r_err;

  logic                 w_fall;
  logic                 w_decide;
  logic                 w_last;
  logic                 w_majority;
  logic                 w_shift_en;
  logic                 w_valid_nxt;
  logic                 w_err_nxt;

  // Bring the asynchronous line into the clock domain and keep one cycle of
  // history for edge detection. The history only starts following the line
  // once the synchronizer holds real samples (two cycles after reset), so
  // the reset value 1 of the synchronizer never pairs with a line that is
  // held low to fake a falling edge.
  always_ff @(posedge RST_clk) begin
    if (RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 1'b0;
      r_fill  <= 2'b00;
    end else begin
      r_sync1 <= rx_bus.uart_rx_data;
      r_sync2 <= r_sync1;
      r_fill  <= {r_fill[0], 1'b1};
      r_hist  <= r_fill[1] ? r_sync2 : 1'b0;
    end
  end

  assign w_fall     = r_hist & ~r_sync2;
  assign w_decide   = (r_clk_cnt == CNT_DECIDE);
  assign w_last     = (r_clk_cnt == CNT_LAST);
  assign w_majority = (r_smp_a & r_smp_b) | (r_smp_a & r_sync2) |
                      (r_smp_b & r_sync2);

  // FSM state register
  always_ff @(posedge RST_clk) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, bit-timing counters and strobe requests
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_clk_cnt + 1'b1;
    w_bit_nxt   = r_bit_idx;
    w_shift_en  = 1'b0;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (w_fall) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_decide && w_majority) begin
          // Line was back high at mid-bit: a glitch, not a start bit.
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_last) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_decide) begin
          w_shift_en = 1'b1;
        end
        if (w_last) begin
          w_cnt_nxt = '0;
          if (r_bit_idx == IDX_LAST) begin
            w_state_nxt = S_STOP;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit_idx + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (w_decide) begin
          // Leave at mid-stop so the next start edge is not missed.
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          if (w_majority) begin
            w_valid_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_bit_nxt   = '0;
      end
    endcase
  end

  // Cycle-in-bit counter and data bit index
  always_ff @(posedge RST_clk) begin
    if (RST) begin
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
    end else begin
      r_clk_cnt <= w_cnt_nxt;
      r_bit_idx <= w_bit_nxt;
    end
  end

  // Capture the two early samples; the third is the live synced line at the
  // decision edge. Decided data bits enter at the LSB so the first received
  // bit ends up in the MSB.
  always_ff @(posedge RST_clk) begin
    if (RST) begin
      r_smp_a <= 1'b1;
      r_smp_b <= 1'b1;
      r_shift <= '0;
    end else begin
      if (r_state != S_IDLE && r_clk_cnt == CNT_SMP_A) begin
        r_smp_a <= r_sync2;
      end
      if (r_state != S_IDLE && r_clk_cnt == CNT_SMP_B) begin
        r_smp_b <= r_sync2;
      end
      if (w_shift_en) begin
        r_shift <= {r_shift[DATA_BITS-2:0], w_majority};
      end
    end
  end

  // Output word and one-cycle strobes; the word is held across frame errors
  always_ff @(posedge RST_clk) begin
    if (RST) begin
      r_rx_data <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      if (w_valid_nxt) begin
        r_rx_data <= r_shift;
      end
    end
  end

  assign rx_bus.rx_data      = r_rx_data;
  assign rx_bus.rx_valid     = r_valid;
  assign rx_bus.rx_frame_err = r_err;
  assign rx_bus.uart_busy    = (r_state != S_IDLE);
  assign o_dbg_state         = r_state;

endmodule
